prim_onehot_rr_arb: RTL and testbench
=====================================

PRIM_ONEHOT_RR_ARB -- requirements
Module: prim_onehot_rr_arb

Interface
REQ-001 SHALL have parameter Inputs, default 8, number of requesters (legal range 1..32).
REQ-002 SHALL have localparam IdxW, 1 when Inputs==1, else $clog2(Inputs); width of the winner index.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  Inputs  per-requester request; held high until the matching gnt_o bit pulses.
REQ-006 SHALL have port gnt_o  output  Inputs  one-hot grant pulse, high in the handshake cycle only.
REQ-007 SHALL have port sel_o  output  Inputs  registered one-hot select that drives the downstream one-hot AND/OR mux; zero when idle.
REQ-008 SHALL have port idx_o  output  IdxW  binary index of the sel_o bit; 0 when idle.
REQ-009 SHALL have port valid_o  output  1  selected requester's data is presented downstream.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the current transfer.

Function
REQ-011 SHALL implement two states: IDLE (valid_o=0, sel_o=0) and HOLD (valid_o=1, sel_o one-hot).
REQ-012 IDLE: any req_i bit set -> winner registered into sel_o/idx_o, state -> HOLD; latency is exactly 1 cycle from req_i to valid_o.
REQ-013 HOLD with ready_i=0: sel_o, idx_o and valid_o SHALL stay stable; gnt_o=0; new requests SHALL NOT change the selection.
REQ-014 HOLD with ready_i=1: gnt_o=sel_o for that cycle; priority pointer <- (idx_o+1) mod Inputs.
REQ-015 The same HOLD/ready_i=1 cycle SHALL arbitrate among req_i & ~sel_o.
- Non-zero result: load the new winner and stay in HOLD, giving back-to-back transfers with no bubble.
- Zero result: go to IDLE.
REQ-016 Round-robin selection SHALL pick the first set request scanning upward from the pointer, wrapping from Inputs-1 to 0.
REQ-017 gnt_o SHALL be combinational from registered sel_o, valid_o and ready_i only; there SHALL be no comb path from req_i to gnt_o.
REQ-018 sel_o SHALL always be one-hot or zero, since the downstream mux requires it.
REQ-019 Withdrawal of a req_i bit that is selected and not yet granted is illegal; the block SHALL flag it with an assertion.
REQ-020 With Inputs==1, the pointer SHALL be constant 0 and the block SHALL degenerate to a single-entry valid/ready handshake.

Reset
REQ-021 rst_ni low SHALL immediately force:
- state IDLE;
- valid_o=0, sel_o=0, idx_o=0;
- pointer 0, hence gnt_o=0.
REQ-022 Reset asserted mid-HOLD SHALL drop the pending transfer with no grant issued; after release, arbitration restarts from pointer 0.

Configuration
REQ-023 Macro PRIM_ONEHOT_RR_ARB_RR_EN defined: round-robin per REQ-014/REQ-016.
REQ-024 Macro PRIM_ONEHOT_RR_ARB_RR_EN undefined:
- fixed priority, lowest set index wins;
- pointer register not instantiated;
- all other behaviour identical.

Verification (Inputs=4; macro defined unless stated)
REQ-025 After reset, req_i=0001, ready_i=1 -> next cycle valid_o=1, sel_o=0001, idx_o=0, gnt_o=0001; the cycle after (req dropped): valid_o=0.
REQ-026 req_i=1111 held with ready_i=1; each requester re-raises the cycle after its grant -> sel_o sequence 0001, 0010, 0100, 1000, 0001, one grant per cycle.
REQ-027 req_i=0110, ready_i=0 for 5 cycles, req_i[3] raised at cycle 2 -> sel_o=0010 stable, gnt_o=0000 throughout; ready_i=1 -> gnt_o=0010, next sel_o=0100.
REQ-028 Pointer wrap: grant idx 3, then req_i=1001 -> sel_o=0001.
REQ-029 rst_ni pulsed low while valid_o=1, sel_o=0100 -> valid_o=0 and sel_o=0000 in the same cycle, no gnt_o; after release, req_i=1100 -> sel_o=0100 (pointer 0).
REQ-030 Macro undefined: req_i=1010 repeatedly re-raised -> sel_o=0010 on every arbitration from IDLE.

Source files
------------

// File: rtl/prim_onehot_rr_arb.sv
// rtl/prim_onehot_rr_arb.sv - one-hot select arbiter with valid/ready handoff
// Define PRIM_ONEHOT_RR_ARB_RR_EN for round-robin; undefined gives fixed priority (lowest index wins).
module prim_onehot_rr_arb #(
  parameter int  Inputs = 8,
  localparam int IdxW   = (Inputs == 1) ? 1 : $clog2(Inputs)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [Inputs-1:0] req_i,
  output logic [Inputs-1:0] gnt_o,
  output logic [Inputs-1:0] sel_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o,
  input  logic              ready_i
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e            r_state, w_state_nxt;
  logic [Inputs-1:0] r_sel, w_sel_nxt, w_cand, w_win;
  logic [IdxW-1:0]   r_idx, w_idx_nxt, w_win_idx, w_base, w_ptr_adv, w_j;
  logic              w_fire, w_found;
  int                w_k;

  assign w_fire    = (r_state == ST_HOLD) && ready_i;
  assign w_ptr_adv = (r_idx == IdxW'(Inputs - 1)) ? '0 : r_idx + IdxW'(1);

`ifdef PRIM_ONEHOT_RR_ARB_RR_EN
  logic [IdxW-1:0] r_ptr;

  // Priority pointer moves just past the requester granted this cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_fire) begin
      r_ptr <= w_ptr_adv;
    end
  end

  // A back-to-back rearbitration must already see the advanced pointer
  assign w_base = (r_state == ST_HOLD) ? w_ptr_adv : r_ptr;
`else
  assign w_base = '0;
`endif

  // While holding, only the other requesters compete for the next slot
  assign w_cand = (r_state == ST_IDLE) ? req_i : (req_i & ~r_sel);

  // Scan upward from the base index, wrapping, and take the first requester
  always_comb begin
    w_win     = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    w_j       = '0;
    for (int i = 0; i < Inputs; i++) begin
      w_k = int'(w_base) + i;
      if (w_k >= Inputs) w_k = w_k - Inputs;
      w_j = IdxW'(w_k);
      if (!w_found && w_cand[w_j]) begin
        w_found    = 1'b1;
        w_win[w_j] = 1'b1;
        w_win_idx  = w_j;
      end
    end
  end

  // State and selection registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: load a winner from idle, or on a handshake load the next one or go idle
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_HOLD;
          w_sel_nxt   = w_win;
          w_idx_nxt   = w_win_idx;
        end
      end
      ST_HOLD: begin
        if (ready_i) begin
          if (w_found) begin
            w_sel_nxt = w_win;
            w_idx_nxt = w_win_idx;
          end else begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
            w_idx_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sel_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign sel_o   = r_sel;
  assign idx_o   = r_idx;
  assign valid_o = (r_state == ST_HOLD);
  assign gnt_o   = r_sel & {Inputs{w_fire}};

`ifndef SYNTHESIS
  // Downstream AND/OR mux needs a one-hot or empty select
  a_sel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(sel_o));
  // A selected requester may not drop its request before being granted
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               valid_o |-> ((req_i & sel_o) == sel_o));
`endif

endmodule

// File: tb/tb_prim_onehot_rr_arb.sv
// tb/tb_prim_onehot_rr_arb.sv - scoreboard bench for prim_onehot_rr_arb (Inputs=4)
module tb_prim_onehot_rr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] sel;
  logic [1:0] idx;
  logic       valid;
  logic       ready;

  int n_checks = 0;
  int n_err    = 0;

  // Reference: selected requester (-1 when idle), pointer, outstanding requests
  int         m_sel = -1;
  int         m_ptr = 0;
  logic [3:0] pend  = '0;
  int         q_state[$];
  int         q_gnt[$];

  prim_onehot_rr_arb #(.Inputs(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .gnt_o  (gnt),
    .sel_o  (sel),
    .idx_o  (idx),
    .valid_o(valid),
    .ready_i(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int base);
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (base + i) % 4;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  function automatic int arb_base(input int p);
`ifdef PRIM_ONEHOT_RR_ARB_RR_EN
    return p;
`else
    return 0;
`endif
  endfunction

  // One clock of stimulus: raise new requests, drive ready, advance the model
  task automatic cycle(input logic [3:0] raise, input logic rdy);
    logic [3:0] cand;
    @(negedge clk);
    q_state.push_back(m_sel);
    pend  = pend | raise;
    req   = pend;
    ready = rdy;
    if (m_sel >= 0) begin
      if (rdy) begin
        q_gnt.push_back(m_sel);
        m_ptr = (m_sel + 1) % 4;
        cand  = pend;
        cand[m_sel] = 1'b0;
        pend[m_sel] = 1'b0;
        m_sel = pick(cand, arb_base(m_ptr));
      end
    end else begin
      m_sel = pick(pend, arb_base(m_ptr));
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    pend  = '0;
    req   = '0;
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_gnt", int'(gnt), 0);
    m_sel = -1;
    m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare registered state every cycle and pop a grant whenever one appears
  always @(negedge clk) begin
    int e;
    #2;
    if (q_state.size() > 0) begin
      e = q_state.pop_front();
      chk("valid", int'(valid), (e >= 0) ? 1 : 0);
      chk("sel", int'(sel), (e >= 0) ? (1 << e) : 0);
      chk("idx", int'(idx), (e >= 0) ? e : 0);
    end
    if (gnt != 4'b0000) begin
      if (q_gnt.size() == 0) begin
        chk("unexpected_gnt", int'(gnt), 0);
      end else begin
        e = q_gnt.pop_front();
        chk("gnt", int'(gnt), 1 << e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ready = 1'b0;
    #3;
    chk("init_valid", int'(valid), 0);
    chk("init_sel", int'(sel), 0);
    chk("init_idx", int'(idx), 0);
    chk("init_gnt", int'(gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request handshake then idle
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // all requesters, continuously re-raised
    repeat (10) cycle(4'b1111, 1'b1);
    repeat (6) cycle(4'b0000, 1'b1);

    // stalled hold with a late request
    cycle(4'b0110, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    repeat (5) cycle(4'b0000, 1'b1);

    // pointer wrap
    cycle(4'b1000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b1001, 1'b1);
    repeat (4) cycle(4'b0000, 1'b1);

    // reset in the middle of a hold
    cycle(4'b0100, 1'b0);
    cycle(4'b0000, 1'b0);
    rst_pulse();
    cycle(4'b1100, 1'b1);
    repeat (4) cycle(4'b0000, 1'b1);

    // fixed-priority pattern (also exercises RR)
    repeat (6) cycle(4'b1010, 1'b1);
    repeat (4) cycle(4'b0000, 1'b1);

    // random traffic with occasional reset
    for (int n = 0; n < 600; n++) begin
      if ((n % 150) == 149) rst_pulse();
      cycle(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    repeat (8) cycle(4'b0000, 1'b1);

    @(negedge clk);
    #4;
    chk("gnt_queue_empty", q_gnt.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
